// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared FSM encoding, default error data and address helpers for the local-bus fabric.
//   No ports; imported by soc_bus_decode and soc_bus_fabric.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        WR_WAIT  = 2'd2,
        ERR_RESP = 2'd3
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Extracts the region-select field addr[msb:lsb] as a plain number.
    function automatic logic [31:0] region_of(input logic [63:0] addr, input int msb, input int lsb);
        logic [63:0] mask;
        mask = (64'd1 << (msb - lsb + 1)) - 64'd1;
        return 32'((addr >> lsb) & mask);
    endfunction

endpackage

// File: rtl/soc_bus_decode.sv
// soc_bus_decode: combinational region decoder for the local-bus fabric.
//   addr     in   master address
//   sel      out  one-hot slave select (all zero when unmapped)
//   idx      out  binary slave index (region value, truncated to 4 bits)
//   unmapped out  region value has no slave behind it
module soc_bus_decode
    import soc_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int SEL_MSB    = 31,
    parameter int SEL_LSB    = 28
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic [3:0]            idx,
    output logic                  unmapped
);

    logic [31:0] region;

    always_comb begin
        region   = region_of(64'(addr), SEL_MSB, SEL_LSB);
        unmapped = region >= 32'(NUM_SLAVES);
        idx      = 4'(region);
        sel      = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            sel[i] = region == 32'(i);
    end

endmodule

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: single-master, N-slave local bus with region decode, one-cycle slave
// strobes, valid/ready slave handshakes, per-access timeout and sticky error capture.
//   clk, reset_n                 clock, asynchronous active-low reset
//   m_addr/m_wdata/m_wmask/m_rstrb  master request (non-zero wmask = write, rstrb = read)
//   m_rdata, m_rbusy, m_wbusy    registered read data and master stall flags
//   s_addr/s_wdata/s_wstrb       registered request fields shared by all slaves
//   s_wen, s_ren                 one-hot, one-cycle slave strobes
//   s_wready, s_rvalid, s_rdata  per-slave handshakes and flattened read data
//   err_clr, err_valid, err_addr, err_is_write  sticky first-error status
module soc_bus_fabric
    import soc_bus_pkg::*;
#(
    parameter int                NUM_SLAVES = 4,
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                SEL_MSB    = 31,
    parameter int                SEL_LSB    = 28,
    parameter int                TIMEOUT    = 15,
    parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_wmask,
    input  logic                         m_rstrb,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_rbusy,
    output logic                         m_wbusy,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    output logic [NUM_SLAVES-1:0]        s_wen,
    output logic [NUM_SLAVES-1:0]        s_ren,
    input  logic [NUM_SLAVES-1:0]        s_wready,
    input  logic [NUM_SLAVES-1:0]        s_rvalid,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic                         err_clr,
    output logic                         err_valid,
    output logic [ADDR_W-1:0]            err_addr,
    output logic                         err_is_write
);

    localparam logic [ADDR_W-1:0] SEL_MASK =
        ADDR_W'(((64'd1 << (SEL_MSB - SEL_LSB + 1)) - 64'd1) << SEL_LSB);

    state_t                  state, state_nxt;
    logic [ADDR_W-1:0]       addr_q;
    logic                    is_write;
    logic [NUM_SLAVES-1:0]   sel_q, dec_sel;
    logic [3:0]              idx_q, dec_idx;
    logic                    dec_unmapped;
    logic [7:0]              cnt;
    logic                    wr_req, req, hs, expired;

    soc_bus_decode #(
        .NUM_SLAVES(NUM_SLAVES),
        .ADDR_W    (ADDR_W),
        .SEL_MSB   (SEL_MSB),
        .SEL_LSB   (SEL_LSB)
    ) u_decode (
        .addr    (m_addr),
        .sel     (dec_sel),
        .idx     (dec_idx),
        .unmapped(dec_unmapped)
    );

    // A write takes priority, so a simultaneous read strobe is simply dropped.
    assign wr_req  = |m_wmask;
    assign req     = wr_req | m_rstrb;
    // Only the targeted slave's handshake counts; strays from other slaves are masked off.
    assign hs      = is_write ? |(sel_q & s_wready) : |(sel_q & s_rvalid);
    // Counter starts at 0 on the strobe cycle, so this marks the TIMEOUT-th wait cycle.
    assign expired = cnt == 8'(TIMEOUT - 1);
    assign s_addr  = addr_q & ~SEL_MASK;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:             if (req) state_nxt = dec_unmapped ? ERR_RESP : (wr_req ? WR_WAIT : RD_WAIT);
            RD_WAIT, WR_WAIT: if (hs) state_nxt = IDLE; else if (expired) state_nxt = ERR_RESP;
            default:          state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_rbusy = (state == RD_WAIT) || (state == ERR_RESP && !is_write);
        m_wbusy = (state == WR_WAIT) || (state == ERR_RESP && is_write);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            is_write     <= 1'b0;
            sel_q        <= '0;
            idx_q        <= '0;
            cnt          <= '0;
            s_wdata      <= '0;
            s_wstrb      <= '0;
            s_wen        <= '0;
            s_ren        <= '0;
            m_rdata      <= '0;
            err_valid    <= 1'b0;
            err_addr     <= '0;
            err_is_write <= 1'b0;
        end else begin
            s_wen <= '0;
            s_ren <= '0;
            if (state == RD_WAIT || state == WR_WAIT)
                cnt <= cnt + 8'd1;
            if (state == IDLE && req) begin
                addr_q   <= m_addr;
                is_write <= wr_req;
                sel_q    <= dec_sel;
                idx_q    <= dec_idx;
                cnt      <= '0;
                // dec_sel is all-zero for an unmapped region, so no slave sees a strobe.
                if (wr_req) begin
                    s_wdata <= m_wdata;
                    s_wstrb <= m_wmask;
                    s_wen   <= dec_sel;
                end else begin
                    s_ren   <= dec_sel;
                end
            end
            if (state == RD_WAIT && hs)
                m_rdata <= s_rdata[int'(idx_q)*DATA_W +: DATA_W];
            if (state == ERR_RESP && !is_write)
                m_rdata <= ERR_DATA;
            // A new error in the same cycle as err_clr is captured rather than cleared.
            if (state == ERR_RESP && (!err_valid || err_clr)) begin
                err_valid    <= 1'b1;
                err_addr     <= addr_q;
                err_is_write <= is_write;
            end else if (err_clr) begin
                err_valid    <= 1'b0;
                err_addr     <= '0;
                err_is_write <= 1'b0;
            end
        end
    end

endmodule
